// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl: sequences a register file and ALU through a Fibonacci run.
// Two seed terms are loaded through the immediate/buffer path, then each
// RUN cycle adds R[k-1] + R[k-2] into R[k] (indices wrap mod NREGS).
// Optional build macro FIB_SAT_STOP_EN: an ALU carry during RUN suppresses
// that write, raises a sticky overflow flag and ends the sequence early.
module fib_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16,
  localparam int RB = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [7:0]       count,
  input  logic             aluCarry,
  output logic [WIDTH-1:0] initialR,
  output logic [RB-1:0]    regWrite,
  output logic [RB-1:0]    regRead1,
  output logic [RB-1:0]    regRead2,
  output logic [3:0]       ALUOp,
  output logic [3:0]       buffCtrl,
  output logic             regWriteEn,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0010;

  localparam logic [3:0] BUF_OFF = 4'b0000;
  localparam logic [3:0] BUF_IMM = 4'b0001;
  localparam logic [3:0] BUF_ALU = 4'b1110;

  typedef enum logic [2:0] {
    IDLE,
    SEED0,
    SEED1,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_k;
  logic [7:0]       r_count;
  logic [WIDTH-1:0] r_seed0;
  logic [WIDTH-1:0] r_seed1;
  logic             w_accept;
  logic             w_last_run;
  logic             w_carry_stop;
  logic [RB-1:0]    w_idx_k;
  logic [RB-1:0]    w_idx_k1;
  logic [RB-1:0]    w_idx_k2;

  assign w_accept   = (r_state == IDLE) && start;
  assign w_last_run = (r_k == 8'(r_count - 8'd1));

  // Register indices for the RUN cycle; truncation to RB bits gives the mod-NREGS wrap.
  assign w_idx_k  = RB'(r_k);
  assign w_idx_k1 = RB'(8'(r_k - 8'd1));
  assign w_idx_k2 = RB'(8'(r_k - 8'd2));

`ifdef FIB_SAT_STOP_EN
  logic r_ovf;

  assign w_carry_stop = (r_state == RUN) && aluCarry;

  // Sticky overflow: set by a RUN-cycle carry, cleared by reset or an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if (w_carry_stop) begin
      r_ovf <= 1'b1;
    end
  end

  assign overflow = r_ovf;
`else
  assign w_carry_stop = 1'b0;
  // Carry has no role here; the AND with zero only keeps the port referenced.
  assign overflow     = 1'b0 & aluCarry;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Term counter and captured sequence parameters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_k     <= '0;
      r_count <= 8'd2;
      r_seed0 <= '0;
      r_seed1 <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_seed0 <= seed0;
            r_seed1 <= seed1;
            r_count <= (count < 8'd2) ? 8'd2 : count;
            r_k     <= '0;
          end
        end
        SEED1:   r_k <= 8'd2;
        RUN:     r_k <= r_k + 8'd1;
        DONE:    r_k <= '0;
        default: ;
      endcase
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (start) w_next = SEED0;
      SEED0: w_next = SEED1;
      SEED1: w_next = (r_count == 8'd2) ? DONE : RUN;
      RUN:   if (w_last_run || w_carry_stop) w_next = DONE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode from registered state and k.
  always_comb begin
    initialR   = '0;
    regWrite   = '0;
    regRead1   = '0;
    regRead2   = '0;
    ALUOp      = OP_AND;
    buffCtrl   = BUF_OFF;
    regWriteEn = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (r_state)
      SEED0: begin
        initialR   = r_seed0;
        regWrite   = '0;
        buffCtrl   = BUF_IMM;
        regWriteEn = 1'b1;
        busy       = 1'b1;
      end
      SEED1: begin
        initialR   = r_seed1;
        regWrite   = RB'(1);
        buffCtrl   = BUF_IMM;
        regWriteEn = 1'b1;
        busy       = 1'b1;
      end
      RUN: begin
        regWrite   = w_idx_k;
        regRead1   = w_idx_k1;
        regRead2   = w_idx_k2;
        ALUOp      = OP_ADD;
        buffCtrl   = BUF_ALU;
        regWriteEn = ~w_carry_stop;
        busy       = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Scoreboard bench for fib_seq_ctrl. The bench owns a register file and ALU
// model driven by the controller outputs; a reference model computes the
// Fibonacci terms per transaction and queues the expected writes and done pulse.
// FIB_SAT_STOP_EN selects the early-stop reference behaviour.
module tb_fib_seq_ctrl;

  localparam int W  = 16;
  localparam int NR = 16;
  localparam int RB = 4;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0010;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  seed0 = '0;
  logic [W-1:0]  seed1 = '0;
  logic [7:0]    count = '0;
  logic          aluCarry;
  logic [W-1:0]  initialR;
  logic [RB-1:0] regWrite, regRead1, regRead2;
  logic [3:0]    ALUOp, buffCtrl;
  logic          regWriteEn, busy, done, overflow;

  fib_seq_ctrl #(.WIDTH(W), .NREGS(NR)) dut (
    .clk(clk), .reset(reset), .start(start), .seed0(seed0), .seed1(seed1),
    .count(count), .aluCarry(aluCarry), .initialR(initialR),
    .regWrite(regWrite), .regRead1(regRead1), .regRead2(regRead2),
    .ALUOp(ALUOp), .buffCtrl(buffCtrl), .regWriteEn(regWriteEn),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned   cyc;
    logic [RB-1:0] idx;
    logic [W-1:0]  val;
    logic          run;
  } wr_t;

  wr_t         wq[$];
  int unsigned dq[$];
  logic [W-1:0] rf [NR];
  int unsigned busy_lo = 1, busy_hi = 0;
  logic        mon_en = 1'b0;
  int          tests = 0, fails = 0;

  // Environment ALU: sum of the two read ports, carry-out on the ALU path.
  logic [W:0] w_sum;
  assign w_sum    = {1'b0, rf[regRead1]} + {1'b0, rf[regRead2]};
  assign aluCarry = (buffCtrl == 4'b1110) & w_sum[W];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT writes or signals done.
  always @(negedge clk) begin
    wr_t           e;
    logic [W-1:0]  v;
    logic [RB-1:0] r1, r2;
    if (mon_en) begin
      if (regWriteEn !== 1'b0) begin
        v = (buffCtrl == 4'b0001) ? initialR : w_sum[W-1:0];
        if (wq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: got write to R%0d at cycle %0d, required none", regWrite, cyc);
        end else begin
          e  = wq.pop_front();
          r1 = e.idx - 1'b1;
          r2 = e.idx - 2'd2;
          chk("write_cycle", cyc, e.cyc);
          chk("write_index", regWrite, e.idx);
          chk("write_data", v, e.val);
          chk("buffCtrl", buffCtrl, e.run ? 4'b1110 : 4'b0001);
          chk("ALUOp", ALUOp, e.run ? OP_ADD : OP_AND);
          if (e.run) begin
            chk("regRead1", regRead1, r1);
            chk("regRead2", regRead2, r2);
          end
        end
        rf[regWrite] <= v;
      end
      if (done !== 1'b0) begin
        if (dq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
        end else begin
          chk("done_cycle", cyc, dq.pop_front());
        end
      end
      chk("busy", busy, (cyc >= busy_lo) && (cyc <= busy_hi));
      if (busy !== 1'b1)
        chk("idle_outputs", {regWriteEn, regWrite, regRead1, regRead2, initialR, ALUOp, buffCtrl},
            {1'b0, 4'd0, 4'd0, 4'd0, 16'd0, OP_AND, 4'b0000});
    end
  end

  // Issue one sequence in IDLE; optional mid-run start pulse, reset, and start held in DONE.
  task automatic run_seq(input logic [W-1:0] a, input logic [W-1:0] b, input logic [7:0] cnt,
                         input int unsigned ign, input int unsigned rst, input bit dstart);
    int unsigned  c, n, stop, last;
    logic [W-1:0] p1, p2, t;
    logic         ovf;
    wr_t          e;
    c = cyc; n = (cnt < 2) ? 2 : cnt; stop = n; ovf = 1'b0; p1 = '0; p2 = '0;
    for (int i = 0; i < int'(n); i++) begin
      if (i == 0) t = a;
      else if (i == 1) t = b;
      else begin
`ifdef FIB_SAT_STOP_EN
        if ((int'(p1) + int'(p2)) >= (1 << W)) begin
          stop = i; ovf = 1'b1; break;
        end
`endif
        t = p1 + p2;
      end
      e.cyc = c + 1 + i; e.idx = RB'(i % NR); e.val = t; e.run = (i >= 2);
      wq.push_back(e);
      p2 = p1; p1 = t;
    end
    last = c + stop + (ovf ? 1 : 0);
    busy_lo = c + 1; busy_hi = last;
    dq.push_back(last + 1);
    start = 1'b1; seed0 = a; seed1 = b; count = cnt;
    while (cyc < last + 2) begin
      @(posedge clk); #1;
      start = 1'b0; seed0 = W'($urandom); seed1 = W'($urandom); count = 8'($urandom);
      if (ign != 0 && cyc == c + ign) start = 1'b1;
      if (dstart && cyc == last + 1) start = 1'b1;
      if (rst != 0 && cyc == c + rst && cyc <= last) begin
        reset = 1'b1;
        while (wq.size() > 0 && wq[$].cyc > cyc) void'(wq.pop_back());
        dq.delete();
        busy_hi = cyc;
        @(posedge clk); #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_wen", regWriteEn, 1'b0);
        chk("reset_overflow", overflow, 1'b0);
        reset = 1'b0;
        return;
      end
    end
    chk("overflow", overflow, ovf);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) rf[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy0", busy, 1'b0);
    chk("reset_done0", done, 1'b0);
    chk("reset_ovf0", overflow, 1'b0);
    chk("reset_wen0", regWriteEn, 1'b0);
    mon_en = 1'b1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_seq(16'd7, 16'd13, 8'd16, 3, 0, 1'b1);
    chk("R0_after16", rf[0], 16'd7);
    chk("R14_after16", rf[14], 16'd6532);
    chk("R15_after16", rf[15], 16'd10569);

    run_seq(16'd7, 16'd13, 8'd20, 0, 0, 1'b0);
`ifdef FIB_SAT_STOP_EN
    chk("R3_kept", rf[3], 16'd33);
`else
    chk("R0_after20", rf[0], 16'd17101);
    chk("R1_after20", rf[1], 16'd27670);
    chk("R2_after20", rf[2], 16'd44771);
    chk("R3_after20", rf[3], 16'd6905);
`endif

    run_seq(16'd5, 16'd9, 8'd0, 0, 0, 1'b0);
    run_seq(16'd11, 16'd4, 8'd1, 0, 0, 1'b1);
    run_seq(16'd3, 16'd8, 8'd2, 0, 0, 1'b0);
    run_seq(16'd7, 16'd13, 8'd16, 0, 5, 1'b0);
    @(posedge clk); #1;
    run_seq(16'd1, 16'd2, 8'd3, 0, 0, 1'b0);

    for (int j = 0; j < 25; j++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      run_seq(W'($urandom_range(0, 2000)), W'($urandom_range(0, 2000)),
              8'($urandom_range(0, 40)), (j % 4 == 0) ? 3 : 0,
              (j % 7 == 3) ? $urandom_range(1, 4) : 0, j[0]);
      if (j % 7 == 3) begin @(posedge clk); #1; end
    end
    run_seq(W'($urandom), W'($urandom), 8'd255, 0, 0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("writes_outstanding", wq.size(), 0);
    chk("done_outstanding", dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
